serial_subtractor_nbit: RTL

Bit-serial N-bit subtractor for the ULA datapath: computes D = A - B - Bin one bit per clock, LSB first, through a 1-bit full-subtractor cell with a registered borrow. It is the subtract-direction counterpart of the ripple adder path. It trades latency for area, and exposes a Start/Busy/Done handshake plus borrow, signed-overflow and zero flags.

---
 rtl/serial_subtractor_nbit.sv | 101 ++++++++++
 1 files changed

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor: D = A - B - Bin, one bit per clock, LSB first,
// with a Start/Busy/Done handshake and registered borrow/overflow/zero flags.
module serial_subtractor_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Ovf,
  output logic             Zero
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sb_q, sr_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             msba_q, msbb_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q, ovf_q, zero_q, done_q;

  // Full-subtractor cell on the current LSBs.
  logic diff_bit, br_nx;
  assign diff_bit = sa_q[0] ^ sb_q[0] ^ br_q;
  assign br_nx    = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sa_q   <= '0;
      sb_q   <= '0;
      sr_q   <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      msba_q <= 1'b0;
      msbb_q <= 1'b0;
      d_q    <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      // Done is registered so it rises together with the result registers.
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: if (Start) begin
          sa_q   <= A;
          sb_q   <= B;
          br_q   <= Bin;
          cnt_q  <= '0;
          msba_q <= A[WIDTH-1];
          msbb_q <= B[WIDTH-1];
        end
        SHIFT: begin
          sr_q  <= {diff_bit, sr_q[WIDTH-1:1]};
          sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
          sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
          br_q  <= br_nx;
          cnt_q <= cnt_q + CW'(1);
        end
        DONE: begin
          d_q    <= sr_q;
          bout_q <= br_q;
          ovf_q  <= (msba_q != msbb_q) && (sr_q[WIDTH-1] != msba_q);
          zero_q <= (sr_q == '0);
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state_q == SHIFT);
  assign Done = done_q;
  assign D    = d_q;
  assign Bout = bout_q;
  assign Ovf  = ovf_q;
  assign Zero = zero_q;
endmodule
